// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: two-requester round-robin APB master.
// Each requester hands over a read or write command and gets a one-cycle
// response pulse with read data and an error flag once the slave completes.
// Optional ACCESS watchdog: define APB_ARB_TIMEOUT_EN to abort transfers
// that stay un-ready for TIMEOUT_CYCLES ACCESS cycles.
module apb_master_arbiter #(
    parameter int ADDR_W         = 9,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                req0_valid,
    input  logic                req0_write,
    input  logic [ADDR_W-1:0]   req0_addr,
    input  logic [DATA_W-1:0]   req0_wdata,
    input  logic [DATA_W/8-1:0] req0_strb,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic                req1_write,
    input  logic [ADDR_W-1:0]   req1_addr,
    input  logic [DATA_W-1:0]   req1_wdata,
    input  logic [DATA_W/8-1:0] req1_strb,
    output logic                req1_ready,
    output logic                rsp0_valid,
    output logic [DATA_W-1:0]   rsp0_rdata,
    output logic                rsp0_err,
    output logic                rsp1_valid,
    output logic [DATA_W-1:0]   rsp1_rdata,
    output logic                rsp1_err,
    output logic                PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [ADDR_W-1:0]   PADDR,
    output logic [DATA_W-1:0]   PWDATA,
    output logic [DATA_W/8-1:0] PSTRB,
    input  logic [DATA_W-1:0]   PRDATA,
    input  logic                PREADY,
    input  logic                PSLVERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state;
    state_t next_state;
    logic   prio;
    logic   owner;
    logic   grant;
    logic   accept;
    logic   done;
    logic   timed_out;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] access_cnt;

    // Count ACCESS cycles of the current transfer; cleared outside ACCESS
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)
            access_cnt <= '0;
        else if (state == ACCESS && !done)
            access_cnt <= access_cnt + CNT_W'(1);
        else
            access_cnt <= '0;
    end

    assign timed_out = (state == ACCESS) && !PREADY &&
                       (access_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timed_out = 1'b0;
`endif

    assign done = (state == ACCESS) && (PREADY || timed_out);

    // State register
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state: completion with a pending command chains straight into SETUP
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = SETUP;
            SETUP:   next_state = ACCESS;
            ACCESS:  if (done) next_state = accept ? SETUP : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Arbitration and handshake; ready is forced low while reset is held
    always_comb begin
        grant      = (req0_valid && req1_valid) ? prio : req1_valid;
        accept     = !PRESET && (req0_valid || req1_valid) &&
                     (state == IDLE || done);
        req0_ready = accept && !grant;
        req1_ready = accept && grant;
    end

    // Registered APB outputs; command fields are captured only on accept
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
            PSTRB   <= '0;
            owner   <= 1'b0;
            prio    <= 1'b0;
        end else begin
            PSEL    <= (next_state != IDLE);
            PENABLE <= (next_state == ACCESS);
            if (accept) begin
                owner  <= grant;
                prio   <= ~grant;
                PWRITE <= grant ? req1_write : req0_write;
                PADDR  <= grant ? req1_addr : req0_addr;
                if (grant) begin
                    PWDATA <= req1_write ? req1_wdata : '0;
                    PSTRB  <= req1_write ? req1_strb : '0;
                end else begin
                    PWDATA <= req0_write ? req0_wdata : '0;
                    PSTRB  <= req0_write ? req0_strb : '0;
                end
            end
        end
    end

    // Response pulse to the owner; data and error hold until its next response
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rsp0_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp0_err   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_rdata <= '0;
            rsp1_err   <= 1'b0;
        end else begin
            rsp0_valid <= done && !owner;
            rsp1_valid <= done && owner;
            if (done && !owner) begin
                rsp0_rdata <= (timed_out || PWRITE) ? '0 : PRDATA;
                rsp0_err   <= timed_out || PSLVERR;
            end
            if (done && owner) begin
                rsp1_rdata <= (timed_out || PWRITE) ? '0 : PRDATA;
                rsp1_err   <= timed_out || PSLVERR;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed scenarios plus randomized traffic for the
// two-requester APB master, checked against a transaction-level model.
// Honors APB_ARB_TIMEOUT_EN the same way the design does.
module tb_apb_master_arbiter;

    localparam int ADDR_W         = 9;
    localparam int DATA_W         = 32;
    localparam int STRB_W         = DATA_W / 8;
    localparam int TIMEOUT_CYCLES = 16;
`ifdef APB_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic              PCLK;
    logic              PRESET;
    logic              req0_valid, req0_write, req0_ready;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic [STRB_W-1:0] req0_strb;
    logic              req1_valid, req1_write, req1_ready;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic [STRB_W-1:0] req1_strb;
    logic              rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [DATA_W-1:0] rsp0_rdata, rsp1_rdata;
    logic              PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA, PRDATA;
    logic [STRB_W-1:0] PSTRB;

    int checks = 0;
    int errors = 0;

    // Transaction-level model: an in-flight transfer plus its age in cycles
    bit                m_busy;
    int                m_cycle;
    bit                m_owner, m_write, m_prio;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [STRB_W-1:0] m_strb;
    bit                m_rv [2];
    logic [DATA_W-1:0] m_rd [2];
    bit                m_re [2];

    apb_master_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_strb(req0_strb), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_strb(req1_strb), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_cycle = 0;
        m_owner = 1'b0;
        m_write = 1'b0;
        m_prio  = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_strb  = '0;
        for (int n = 0; n < 2; n++) begin
            m_rv[n] = 1'b0;
            m_rd[n] = '0;
            m_re[n] = 1'b0;
        end
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0; req0_strb = '0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0; req1_strb = '0;
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    endtask

    // Compare registered outputs against the model (called at negedge)
    task automatic check_output();
        chk("psel", 64'(PSEL), 64'(m_busy));
        chk("penable", 64'(PENABLE), 64'(m_busy && m_cycle >= 1));
        if (m_busy) begin
            chk("paddr", 64'(PADDR), 64'(m_addr));
            chk("pwrite", 64'(PWRITE), 64'(m_write));
            chk("pwdata", 64'(PWDATA), 64'(m_write ? m_wdata : '0));
            chk("pstrb", 64'(PSTRB), 64'(m_write ? m_strb : '0));
        end
        chk("rsp0_valid", 64'(rsp0_valid), 64'(m_rv[0]));
        chk("rsp0_rdata", 64'(rsp0_rdata), 64'(m_rd[0]));
        chk("rsp0_err", 64'(rsp0_err), 64'(m_re[0]));
        chk("rsp1_valid", 64'(rsp1_valid), 64'(m_rv[1]));
        chk("rsp1_rdata", 64'(rsp1_rdata), 64'(m_rd[1]));
        chk("rsp1_err", 64'(rsp1_err), 64'(m_re[1]));
    endtask

    // One clock: check handshake, advance the model, then check outputs
    task automatic cycle();
        bit any, grant, tmo, complete, acc;
        #1;
        any      = req0_valid || req1_valid;
        grant    = (req0_valid && req1_valid) ? m_prio : req1_valid;
        tmo      = TMO_EN && m_busy && (m_cycle == TIMEOUT_CYCLES) && !PREADY;
        complete = m_busy && (m_cycle >= 1) && (PREADY || tmo);
        acc      = any && (!m_busy || complete);
        chk("req0_ready", 64'(req0_ready), 64'(acc && !grant));
        chk("req1_ready", 64'(req1_ready), 64'(acc && grant));
        m_rv[0] = 1'b0;
        m_rv[1] = 1'b0;
        if (complete) begin
            m_rv[m_owner] = 1'b1;
            m_rd[m_owner] = (tmo || m_write) ? '0 : PRDATA;
            m_re[m_owner] = tmo ? 1'b1 : PSLVERR;
        end
        if (acc) begin
            m_owner = grant;
            m_write = grant ? req1_write : req0_write;
            m_addr  = grant ? req1_addr : req0_addr;
            m_wdata = grant ? req1_wdata : req0_wdata;
            m_strb  = grant ? req1_strb : req0_strb;
            m_prio  = !grant;
            m_busy  = 1'b1;
            m_cycle = 0;
        end else if (complete) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_cycle++;
        end
        @(posedge PCLK);
        @(negedge PCLK);
        check_output();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_psel"}, 64'(PSEL), 64'(0));
        chk({tag, "_penable"}, 64'(PENABLE), 64'(0));
        chk({tag, "_pwrite"}, 64'(PWRITE), 64'(0));
        chk({tag, "_paddr"}, 64'(PADDR), 64'(0));
        chk({tag, "_pwdata"}, 64'(PWDATA), 64'(0));
        chk({tag, "_pstrb"}, 64'(PSTRB), 64'(0));
        chk({tag, "_ready0"}, 64'(req0_ready), 64'(0));
        chk({tag, "_ready1"}, 64'(req1_ready), 64'(0));
        chk({tag, "_rsp0"}, 64'({rsp0_valid, rsp0_err, rsp0_rdata}), 64'(0));
        chk({tag, "_rsp1"}, 64'({rsp1_valid, rsp1_err, rsp1_rdata}), 64'(0));
    endtask

    // Asynchronous reset pulse mid-cycle with requests pending
    task automatic do_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #2 PRESET = 1'b1;
        #1 check_all_zero("async_rst");
        model_reset();
        @(posedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;
    endtask

    task automatic apply_stimulus();
        req0_valid = ($urandom_range(0, 9) < 6);
        req0_write = $urandom_range(0, 1) == 1;
        req0_addr  = ADDR_W'($urandom);
        req0_wdata = $urandom;
        req0_strb  = STRB_W'($urandom);
        req1_valid = ($urandom_range(0, 9) < 6);
        req1_write = $urandom_range(0, 1) == 1;
        req1_addr  = ADDR_W'($urandom);
        req1_wdata = $urandom;
        req1_strb  = STRB_W'($urandom);
        PREADY     = ($urandom_range(0, 9) < 6);
        PSLVERR    = ($urandom_range(0, 4) == 0);
        PRDATA     = $urandom;
    endtask

    initial begin
        PRESET = 1'b1;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge PCLK);
        check_all_zero("reset");
        PRESET = 1'b0;

        // Single zero-wait write from requester 0
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 9'h004;
        req0_wdata = 32'hDEADBEEF; req0_strb = 4'hF; PREADY = 1'b1;
        cycle();
        req0_valid = 1'b0;
        chk("wr_psel_setup", 64'(PSEL), 64'(1));
        chk("wr_penable_setup", 64'(PENABLE), 64'(0));
        chk("wr_pstrb", 64'(PSTRB), 64'(4'hF));
        chk("wr_pwdata", 64'(PWDATA), 64'(32'hDEADBEEF));
        cycle();
        chk("wr_psel_access", 64'(PSEL), 64'(1));
        chk("wr_penable_access", 64'(PENABLE), 64'(1));
        cycle();
        chk("wr_psel_done", 64'(PSEL), 64'(0));
        chk("wr_rsp0_valid", 64'(rsp0_valid), 64'(1));
        chk("wr_rsp0_err", 64'(rsp0_err), 64'(0));
        chk("wr_rsp0_rdata", 64'(rsp0_rdata), 64'(0));
        cycle();
        chk("wr_rsp0_pulse_end", 64'(rsp0_valid), 64'(0));

        // Read from requester 1 with three wait states
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 9'h1FC;
        req1_wdata = 32'hCAFEF00D; req1_strb = 4'hF;
        PREADY = 1'b0; PRDATA = 32'h12345678;
        cycle();
        req1_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("rd_paddr_stable", 64'(PADDR), 64'(9'h1FC));
            chk("rd_pstrb_zero", 64'(PSTRB), 64'(0));
            chk("rd_pwdata_zero", 64'(PWDATA), 64'(0));
            PREADY = (k == 4);
            cycle();
        end
        chk("rd_rsp1_valid", 64'(rsp1_valid), 64'(1));
        chk("rd_rsp1_rdata", 64'(rsp1_rdata), 64'(32'h12345678));
        chk("rd_rsp1_err", 64'(rsp1_err), 64'(0));
        PREADY = 1'b0;
        cycle();

        // Continuous contention: alternating grants, no idle gap
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 9'h0A0; req0_wdata = 32'h11111111;
        req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 9'h0B0; req1_wdata = 32'h22222222;
        PREADY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                #1;
                chk("rr_grant0", 64'(req0_ready), 64'((i / 2) % 2 == 0));
                chk("rr_grant1", 64'(req1_ready), 64'((i / 2) % 2 == 1));
            end
            cycle();
            chk("rr_no_idle", 64'(PSEL), 64'(1));
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cycle();
        cycle();

        // Slave error on a read
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 9'h010;
        PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'h0BADF00D;
        cycle();
        req0_valid = 1'b0;
        cycle();
        cycle();
        chk("err_rsp0_valid", 64'(rsp0_valid), 64'(1));
        chk("err_rsp0_err", 64'(rsp0_err), 64'(1));
        PSLVERR = 1'b0;
        cycle();

        // Slave never ready
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 9'h020;
        PREADY = 1'b0; PRDATA = 32'h55AA55AA;
        cycle();
        req0_valid = 1'b0;
        for (int k = 0; k < 17; k++) begin
            chk("tmo_psel_held", 64'(PSEL), 64'(1));
            cycle();
        end
`ifdef APB_ARB_TIMEOUT_EN
        chk("tmo_psel_drop", 64'(PSEL), 64'(0));
        chk("tmo_rsp0_valid", 64'(rsp0_valid), 64'(1));
        chk("tmo_rsp0_err", 64'(rsp0_err), 64'(1));
        chk("tmo_rsp0_rdata", 64'(rsp0_rdata), 64'(0));
        cycle();
`else
        chk("wait_psel_still", 64'(PSEL), 64'(1));
        chk("wait_penable_still", 64'(PENABLE), 64'(1));
        PREADY = 1'b1;
        cycle();
        chk("wait_rsp0_rdata", 64'(rsp0_rdata), 64'(32'h55AA55AA));
        PREADY = 1'b0;
        cycle();
`endif

        // Reset during ACCESS, then restart with requester 0 priority
        req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 9'h030; req1_wdata = 32'h33333333;
        PREADY = 1'b0;
        cycle();
        req1_valid = 1'b0;
        cycle();
        cycle();
        do_reset();
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 9'h040;
        req1_valid = 1'b1;
        #1;
        chk("post_rst_grant0", 64'(req0_ready), 64'(1));
        chk("post_rst_grant1", 64'(req1_ready), 64'(0));
        cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        PREADY = 1'b1;
        repeat (3) cycle();

        // Randomized traffic with occasional asynchronous reset
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0)
                do_reset();
            apply_stimulus();
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
